// File: rtl/sys_rst_seq_pkg.sv
// sys_rst_seq_pkg: shared types and constants for the PCIe reset sequencer.
//   state_e         : 3-bit sequencer state encoding (also exported on bus.state)
//   DEF_*           : default delay / timeout values, in sys_clk cycles
//   max3()          : helper used to size the shared counter
package sys_rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_PERST     = 3'd0,
      ST_WAIT_LINK = 3'd1,
      ST_USER_RST  = 3'd2,
      ST_DONE      = 3'd3,
      ST_FAIL      = 3'd4
   } state_e;

   localparam int unsigned DEF_PERST_DLY    = 100;
   localparam int unsigned DEF_USER_RST_DLY = 16;
   localparam int unsigned DEF_LINK_TIMEOUT = 4096;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sys_rst_seq_if.sv
// sys_rst_seq_if: control/status bundle of the reset sequencer.
//   req_rst    : synchronous warm-reset request (to sequencer)
//   link_up    : asynchronous link status from the endpoint (to sequencer)
//   perst_n    : PCIe fundamental reset, active-low (from sequencer)
//   user_rst_n : downstream user-logic reset, active-low (from sequencer)
//   seq_done   : high only while the sequence is complete (from sequencer)
//   timeout    : sticky link-up failure flag (from sequencer)
//   state      : current state encoding, for debug (from sequencer)
// modport slave is the sequencer side, modport master the controlling side.
interface sys_rst_seq_if;

   logic       req_rst;
   logic       link_up;
   logic       perst_n;
   logic       user_rst_n;
   logic       seq_done;
   logic       timeout;
   logic [2:0] state;

   modport master (
      output req_rst, link_up,
      input  perst_n, user_rst_n, seq_done, timeout, state
   );

   modport slave (
      input  req_rst, link_up,
      output perst_n, user_rst_n, seq_done, timeout, state
   );

endinterface

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: two-flop synchronizer with asynchronous active-low reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
module rst_seq_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/sys_rst_seq.sv
// sys_rst_seq: PCIe power-up / warm reset sequencer.
//   sys_clk   : single clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : sys_rst_seq_if.slave (req_rst, link_up in; perst_n,
//               user_rst_n, seq_done, timeout, state out)
// Sequence: PERST (perst_n low for PERST_DLY edges) -> WAIT_LINK (until the
// synchronized link is up, or FAIL after LINK_TIMEOUT) -> USER_RST (user reset
// held USER_RST_DLY edges) -> DONE. Link loss in USER_RST/DONE returns to
// WAIT_LINK; req_rst restarts from PERST from any state.
module sys_rst_seq
   import sys_rst_seq_pkg::*;
#(
   parameter int unsigned PERST_DLY    = DEF_PERST_DLY,
   parameter int unsigned USER_RST_DLY = DEF_USER_RST_DLY,
   parameter int unsigned LINK_TIMEOUT = DEF_LINK_TIMEOUT
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   sys_rst_seq_if.slave  bus
);

   localparam int unsigned CW = $clog2(max3(PERST_DLY, USER_RST_DLY, LINK_TIMEOUT) + 1);

   // PERST/USER_RST leave on the N-th edge in state, so they compare against
   // N-1; WAIT_LINK fails on the cycle the count has reached LINK_TIMEOUT.
   localparam logic [CW-1:0] PERST_LAST = CW'(PERST_DLY - 1);
   localparam logic [CW-1:0] USER_LAST  = CW'(USER_RST_DLY - 1);
   localparam logic [CW-1:0] LINK_LAST  = CW'(LINK_TIMEOUT);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          perst_n_q, perst_n_d;
   logic          user_rst_n_q, user_rst_n_d;
   logic          seq_done_q, seq_done_d;
   logic          timeout_q, timeout_d;
   logic          link_s;

   rst_seq_sync u_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (bus.link_up),
      .q     (link_s)
   );

   always_comb begin
      state_d = state_q;

      if (bus.req_rst) begin
         state_d = ST_PERST;
      end else begin
         case (state_q)
            ST_PERST: begin
               if (cnt_q == PERST_LAST) state_d = ST_WAIT_LINK;
            end
            ST_WAIT_LINK: begin
               // link-up is tested first so it wins a same-cycle timeout
               if (link_s)                  state_d = ST_USER_RST;
               else if (cnt_q == LINK_LAST) state_d = ST_FAIL;
            end
            ST_USER_RST: begin
               if (!link_s)                 state_d = ST_WAIT_LINK;
               else if (cnt_q == USER_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
               if (!link_s) state_d = ST_WAIT_LINK;
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_PERST;
            end
         endcase
      end

      // one shared counter: cleared on every state change or request,
      // otherwise counts up and saturates at all-ones
      if (bus.req_rst || (state_d != state_q)) begin
         cnt_d = '0;
      end else if (cnt_q == '1) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // outputs decoded from the next state so every port is a plain flop
      perst_n_d    = (state_d != ST_PERST);
      user_rst_n_d = (state_d == ST_DONE);
      seq_done_d   = (state_d == ST_DONE);
      timeout_d    = (state_d == ST_FAIL);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_PERST;
         cnt_q        <= '0;
         perst_n_q    <= 1'b0;
         user_rst_n_q <= 1'b0;
         seq_done_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         perst_n_q    <= perst_n_d;
         user_rst_n_q <= user_rst_n_d;
         seq_done_q   <= seq_done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.perst_n    = perst_n_q;
   assign bus.user_rst_n = user_rst_n_q;
   assign bus.seq_done   = seq_done_q;
   assign bus.timeout    = timeout_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// tb_sys_rst_seq: directed bench for sys_rst_seq with PERST_DLY=100,
// USER_RST_DLY=16, LINK_TIMEOUT=200. Inputs change and outputs are sampled
// 1 time unit after a rising edge.
module tb_sys_rst_seq;
   import sys_rst_seq_pkg::*;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   sys_rst_seq_if bus ();

   sys_rst_seq #(
      .PERST_DLY    (100),
      .USER_RST_DLY (16),
      .LINK_TIMEOUT (200)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step(input int unsigned n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] st, input logic p,
                      input logic u, input logic d, input logic t);
      logic [6:0] obs;
      logic [6:0] exp;
      obs = {bus.state, bus.perst_n, bus.user_rst_n, bus.seq_done, bus.timeout};
      exp = {st, p, u, d, t};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed state=%0d perst_n=%b user_rst_n=%b seq_done=%b timeout=%b, expected state=%0d perst_n=%b user_rst_n=%b seq_done=%b timeout=%b",
                tag, obs[6:4], obs[3], obs[2], obs[1], obs[0], st, p, u, d, t);
      end
   endtask

   initial begin
      bus.req_rst = 1'b0;
      bus.link_up = 1'b0;
      sys_rst_n   = 1'b1;

      // power-on reset
      #1 sys_rst_n = 1'b0;
      #1 chk("reset_async", ST_PERST, 0, 0, 0, 0);
      step(2);
      chk("reset_held", ST_PERST, 0, 0, 0, 0);
      sys_rst_n = 1'b1;

      // nominal: perst_n rises on edge 100
      step(1);
      chk("perst_edge1", ST_PERST, 0, 0, 0, 0);
      step(98);
      chk("perst_edge99", ST_PERST, 0, 0, 0, 0);
      step(1);
      chk("perst_rise_edge100", ST_WAIT_LINK, 1, 0, 0, 0);
      step(50);
      chk("wait_link_50", ST_WAIT_LINK, 1, 0, 0, 0);
      bus.link_up = 1'b1;
      step(2);
      chk("link_sync_2", ST_WAIT_LINK, 1, 0, 0, 0);
      step(1);
      chk("user_rst_entry", ST_USER_RST, 1, 0, 0, 0);
      step(15);
      chk("user_rst_last", ST_USER_RST, 1, 0, 0, 0);
      step(1);
      chk("done_19", ST_DONE, 1, 1, 1, 0);

      // link drop in DONE and restore
      bus.link_up = 1'b0;
      step(2);
      chk("drop_2", ST_DONE, 1, 1, 1, 0);
      step(1);
      chk("drop_wait_link", ST_WAIT_LINK, 1, 0, 0, 0);
      bus.link_up = 1'b1;
      step(2);
      chk("restore_2", ST_WAIT_LINK, 1, 0, 0, 0);
      step(1);
      chk("restore_user_rst", ST_USER_RST, 1, 0, 0, 0);
      step(15);
      chk("restore_user_last", ST_USER_RST, 1, 0, 0, 0);
      step(1);
      chk("restore_done", ST_DONE, 1, 1, 1, 0);

      // warm reset, then link never comes up -> FAIL on edge 100+200+1
      bus.link_up = 1'b0;
      bus.req_rst = 1'b1;
      step(1);
      chk("req_rst_from_done", ST_PERST, 0, 0, 0, 0);
      bus.req_rst = 1'b0;
      step(99);
      chk("perst2_edge99", ST_PERST, 0, 0, 0, 0);
      step(1);
      chk("perst2_rise", ST_WAIT_LINK, 1, 0, 0, 0);
      step(200);
      chk("timeout_edge300", ST_WAIT_LINK, 1, 0, 0, 0);
      step(1);
      chk("fail_edge301", ST_FAIL, 1, 0, 0, 1);
      bus.link_up = 1'b1;
      step(5);
      chk("fail_sticky", ST_FAIL, 1, 0, 0, 1);

      // recovery from FAIL with a one-cycle req_rst
      bus.link_up = 1'b0;
      bus.req_rst = 1'b1;
      step(1);
      chk("recover_req_rst", ST_PERST, 0, 0, 0, 0);
      bus.req_rst = 1'b0;
      step(99);
      chk("recover_edge99", ST_PERST, 0, 0, 0, 0);
      step(1);
      chk("recover_rise", ST_WAIT_LINK, 1, 0, 0, 0);

      // race: link_s rises on the cycle the count reaches LINK_TIMEOUT
      step(198);
      bus.link_up = 1'b1;
      step(2);
      chk("race_pre", ST_WAIT_LINK, 1, 0, 0, 0);
      step(1);
      chk("race_link_wins", ST_USER_RST, 1, 0, 0, 0);

      // async reset 8 cycles into USER_RST
      step(8);
      chk("user_rst_8", ST_USER_RST, 1, 0, 0, 0);
      #2 sys_rst_n = 1'b0;
      #1 chk("async_reset_mid", ST_PERST, 0, 0, 0, 0);
      step(1);
      chk("async_reset_edge", ST_PERST, 0, 0, 0, 0);
      sys_rst_n = 1'b1;
      step(99);
      chk("post_reset_edge99", ST_PERST, 0, 0, 0, 0);
      step(1);
      chk("post_reset_rise", ST_WAIT_LINK, 1, 0, 0, 0);
      step(1);
      chk("post_reset_link", ST_USER_RST, 1, 0, 0, 0);

      // req_rst held keeps PERST with the count at zero
      bus.req_rst = 1'b1;
      step(4);
      chk("req_rst_held", ST_PERST, 0, 0, 0, 0);
      bus.req_rst = 1'b0;
      step(99);
      chk("held_release_edge99", ST_PERST, 0, 0, 0, 0);
      step(1);
      chk("held_release_rise", ST_WAIT_LINK, 1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
